// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding imem request, one-entry
// output buffer toward decode, PC redirect with stale-response discard.
module fetch_sequencer #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter int                PC_INC   = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    output logic [ADDR_W-1:0] pc
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DISCARD
    } state_t;

    state_t            state;
    state_t            state_nxt;
    state_t            resume;
    logic              take;
    logic              load_addr;
    logic [ADDR_W-1:0] pc_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        resume    = enable ? FETCH : IDLE;
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (!redirect_valid && enable) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (redirect_valid) begin
                    state_nxt = imem_ack ? resume : DISCARD;
                end else if (imem_ack) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid || inst_ready) begin
                    state_nxt = resume;
                end
            end
            DISCARD: begin
                if (imem_ack) begin
                    state_nxt = resume;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        imem_req = (state == FETCH) || (state == DISCARD);
        take     = (state == FETCH) && imem_ack && !redirect_valid;
        if (redirect_valid) begin
            pc_nxt = redirect_pc;
        end else if (take) begin
            pc_nxt = pc + ADDR_W'(PC_INC);
        end else begin
            pc_nxt = pc;
        end
        // A waiting FETCH keeps its address; any other entry into FETCH reloads it.
        load_addr = (state_nxt == FETCH) &&
                    !((state == FETCH) && !imem_ack);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RESET_PC;
            imem_addr  <= RESET_PC;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
        end else begin
            pc <= pc_nxt;
            if (load_addr) begin
                imem_addr <= pc_nxt;
            end
            if (take) begin
                inst    <= imem_rdata;
                inst_pc <= imem_addr;
            end
            if (take) begin
                inst_valid <= 1'b1;
            end else if (redirect_valid || inst_ready) begin
                inst_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: vector table, directed corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_fetch_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        inst_ready = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        inst_valid;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic [15:0] pc;

    fetch_sequencer u_dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready),
        .pc            (pc)
    );

    logic        w_reset = 1'b1;
    logic        w_enable = 1'b0;
    logic        w_rv = 1'b0;
    logic [15:0] w_rpc = '0;
    logic        w_ack = 1'b0;
    logic [15:0] w_rdata;
    logic        w_ready = 1'b0;
    logic        w_req;
    logic [15:0] w_addr;
    logic        w_valid;
    logic [15:0] w_inst;
    logic [15:0] w_ipc;
    logic [15:0] w_pc;

    assign w_rdata = w_addr ^ 16'hA5A5;

    fetch_sequencer #(.RESET_PC(16'hFFFE)) u_wrap (
        .clk           (clk),
        .reset         (w_reset),
        .enable        (w_enable),
        .redirect_valid(w_rv),
        .redirect_pc   (w_rpc),
        .imem_req      (w_req),
        .imem_addr     (w_addr),
        .imem_ack      (w_ack),
        .imem_rdata    (w_rdata),
        .inst_valid    (w_valid),
        .inst          (w_inst),
        .inst_pc       (w_ipc),
        .inst_ready    (w_ready),
        .pc            (w_pc)
    );

    int nvec = 0;
    int errs = 0;

    // Reference model: an outstanding-request flag, a stale flag for
    // responses to drop, and the decode buffer contents.
    logic        m_busy = 1'b0;
    logic        m_stale = 1'b0;
    logic        m_bv = 1'b0;
    logic [15:0] m_inst = '0;
    logic [15:0] m_ipc = '0;
    logic [15:0] m_pc = '0;
    logic [15:0] m_addr = '0;

    task automatic model_step();
        logic [15:0] npc;
        logic        good, bv, busy, was_idle, start;
        if (reset) begin
            m_busy  = 1'b0;
            m_stale = 1'b0;
            m_bv    = 1'b0;
            m_inst  = '0;
            m_ipc   = '0;
            m_pc    = '0;
            m_addr  = '0;
            return;
        end
        was_idle = !m_busy && !m_bv;
        good = m_busy && imem_ack && !m_stale && !redirect_valid;
        npc = m_pc;
        bv = m_bv;
        if (redirect_valid || inst_ready) bv = 1'b0;
        if (good) begin
            bv     = 1'b1;
            m_inst = imem_rdata;
            m_ipc  = m_addr;
            npc    = m_pc + 16'd1;
        end
        if (redirect_valid) npc = redirect_pc;
        busy = m_busy && !imem_ack;
        if (busy && redirect_valid) m_stale = 1'b1;
        if (!busy) m_stale = 1'b0;
        start = enable && !busy && !bv && !(was_idle && redirect_valid);
        if (start) begin
            busy   = 1'b1;
            m_addr = npc;
        end
        m_busy = busy;
        m_bv   = bv;
        m_pc   = npc;
    endtask

    task automatic cyc(input logic r, input logic e, input logic rv,
                       input logic [15:0] rpc, input logic a,
                       input logic [15:0] rd, input logic rdy);
        @(negedge clk);
        reset          = r;
        enable         = e;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_ack       = a;
        imem_rdata     = rd;
        inst_ready     = rdy;
        @(posedge clk);
        model_step();
        #1;
        nvec++;
        if (imem_req !== m_busy || imem_addr !== m_addr ||
            inst_valid !== m_bv || inst !== m_inst ||
            inst_pc !== m_ipc || pc !== m_pc) begin
            errs++;
            $display("FAIL model t=%0t got req=%b addr=%h v=%b inst=%h ipc=%h pc=%h exp req=%b addr=%h v=%b inst=%h ipc=%h pc=%h",
                     $time, imem_req, imem_addr, inst_valid, inst, inst_pc, pc,
                     m_busy, m_addr, m_bv, m_inst, m_ipc, m_pc);
        end
    endtask

    task automatic chk(input string n, input logic [15:0] act,
                       input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s got %h exp %h", n, act, exp);
        end
    endtask

    typedef struct {
        logic        rst, en, rv;
        logic [15:0] rpc;
        logic        ack;
        logic [15:0] rd;
        logic        rdy;
        logic        req;
        logic [15:0] addr;
        logic        val;
        logic [15:0] inst, ipc, pc;
    } vec_t;

    vec_t tbl[10];
    logic [15:0] wexp[3];

    initial begin
        // zero-wait memory returning addr^A5A5, decode always ready
        tbl[0] = '{1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0,
                   1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0,
                   1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'hA5A5, 1'b1,
                   1'b0, 16'h0000, 1'b1, 16'hA5A5, 16'h0000, 16'h0001};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1,
                   1'b1, 16'h0001, 1'b0, 16'hA5A5, 16'h0000, 16'h0001};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'hA5A4, 1'b1,
                   1'b0, 16'h0001, 1'b1, 16'hA5A4, 16'h0001, 16'h0002};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1,
                   1'b1, 16'h0002, 1'b0, 16'hA5A4, 16'h0001, 16'h0002};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'hA5A7, 1'b1,
                   1'b0, 16'h0002, 1'b1, 16'hA5A7, 16'h0002, 16'h0003};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1,
                   1'b1, 16'h0003, 1'b0, 16'hA5A7, 16'h0002, 16'h0003};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'hA5A6, 1'b1,
                   1'b0, 16'h0003, 1'b1, 16'hA5A6, 16'h0003, 16'h0004};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1,
                   1'b0, 16'h0003, 1'b0, 16'hA5A6, 16'h0003, 16'h0004};
        wexp[0] = 16'hFFFE;
        wexp[1] = 16'hFFFF;
        wexp[2] = 16'h0000;

        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].rst, tbl[i].en, tbl[i].rv, tbl[i].rpc,
                tbl[i].ack, tbl[i].rd, tbl[i].rdy);
            nvec++;
            if (imem_req !== tbl[i].req || imem_addr !== tbl[i].addr ||
                inst_valid !== tbl[i].val || inst !== tbl[i].inst ||
                inst_pc !== tbl[i].ipc || pc !== tbl[i].pc) begin
                errs++;
                $display("FAIL table[%0d] got req=%b addr=%h v=%b inst=%h ipc=%h pc=%h exp req=%b addr=%h v=%b inst=%h ipc=%h pc=%h",
                         i, imem_req, imem_addr, inst_valid, inst, inst_pc, pc,
                         tbl[i].req, tbl[i].addr, tbl[i].val, tbl[i].inst,
                         tbl[i].ipc, tbl[i].pc);
            end
        end

        // three wait states, then decode stalls four cycles
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("ws_req", imem_req, 1);
        repeat (3) begin
            cyc(0, 1, 0, 0, 0, 0, 0);
            chk("ws_req_hold", imem_req, 1);
            chk("ws_addr", imem_addr, 0);
        end
        cyc(0, 1, 0, 0, 1, 16'h1234, 0);
        chk("ws_valid", inst_valid, 1);
        repeat (4) begin
            cyc(0, 1, 0, 0, 0, 0, 0);
            chk("hold_inst", inst, 16'h1234);
            chk("hold_ipc", inst_pc, 0);
            chk("hold_req", imem_req, 0);
        end
        cyc(0, 1, 0, 0, 0, 0, 1);
        chk("rel_req", imem_req, 1);
        chk("rel_addr", imem_addr, 1);
        chk("rel_valid", inst_valid, 0);

        // redirect while fetch of 0005 is waiting
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 16'h0005, 0, 0, 0);
        chk("idle_redir_pc", pc, 16'h0005);
        chk("idle_redir_req", imem_req, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("f5_addr", imem_addr, 16'h0005);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 16'h0100, 0, 0, 0);
        chk("disc_req", imem_req, 1);
        chk("disc_addr", imem_addr, 16'h0005);
        chk("disc_pc", pc, 16'h0100);
        cyc(0, 1, 0, 0, 1, 16'hDEAD, 1);
        chk("disc_drop", inst_valid, 0);
        chk("disc_next", imem_addr, 16'h0100);
        cyc(0, 1, 0, 0, 1, 16'hBEEF, 0);
        chk("disc_dv", inst_valid, 1);
        chk("disc_dpc", inst_pc, 16'h0100);
        chk("disc_dinst", inst, 16'hBEEF);

        // redirect in HOLD holding inst_pc 7
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 16'h0007, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 16'h0707, 0);
        chk("h7_ipc", inst_pc, 16'h0007);
        chk("h7_valid", inst_valid, 1);
        cyc(0, 1, 1, 16'h0200, 0, 0, 0);
        chk("hr_valid", inst_valid, 0);
        chk("hr_addr", imem_addr, 16'h0200);
        chk("hr_req", imem_req, 1);
        cyc(0, 1, 0, 0, 1, 16'h2222, 0);
        chk("hr_ipc", inst_pc, 16'h0200);
        chk("hr_inst", inst, 16'h2222);

        // reset with a same-cycle ack
        cyc(0, 1, 0, 0, 0, 0, 1);
        chk("rf_addr", imem_addr, 16'h0201);
        cyc(1, 1, 0, 0, 1, 16'hFFFF, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_ipc", inst_pc, 0);
        chk("rst_pc", pc, 0);
        chk("rst_addr", imem_addr, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("rst_idle", imem_req, 0);

        // enable dropped mid-fetch
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("en_req", imem_req, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("en_off_req", imem_req, 1);
        cyc(0, 0, 0, 0, 1, 16'h5555, 0);
        chk("en_off_valid", inst_valid, 1);
        chk("en_off_inst", inst, 16'h5555);
        chk("en_off_pc", pc, 16'h0001);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("en_off_rel", inst_valid, 0);
        chk("en_off_noreq", imem_req, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("en_off_idle", imem_req, 0);

        // pc wrap on the RESET_PC=FFFE instance
        @(negedge clk);
        w_reset = 1'b1;
        @(negedge clk);
        w_reset  = 1'b0;
        w_enable = 1'b1;
        w_ack    = 1'b1;
        w_ready  = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            if (k % 2 == 0) begin
                chk("wrap_valid", w_valid, 1);
                chk("wrap_ipc", w_ipc, wexp[k/2-1]);
            end
        end
        chk("wrap_pc", w_pc, 16'h0001);
        w_enable = 1'b0;

        // randomized traffic
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom % 256) == 0, ($urandom % 4) != 0,
                ($urandom % 12) == 0, 16'($urandom),
                ($urandom % 3) == 0, 16'($urandom),
                ($urandom % 2) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

endmodule
